alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Two-requester ALU front end: arbitrates between req0/req1, latches the
// granted operation, computes one registered result and holds it on a shared
// response bus until the granted requester consumes it.
// Optional macro ALU_ARB_ROUND_ROBIN_EN: when defined, simultaneous requests
// alternate between the two requesters; otherwise requester 0 always wins.
module alu_arbiter #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,

  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic [3:0]        req0_op_i,
  input  logic [DATA_W-1:0] req0_a_i,
  input  logic [DATA_W-1:0] req0_b_i,
  input  logic [4:0]        req0_shamt_i,

  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic [3:0]        req1_op_i,
  input  logic [DATA_W-1:0] req1_a_i,
  input  logic [DATA_W-1:0] req1_b_i,
  input  logic [4:0]        req1_shamt_i,

  output logic              rsp0_valid_o,
  input  logic              rsp0_ready_i,
  output logic              rsp1_valid_o,
  input  logic              rsp1_ready_i,

  output logic [DATA_W-1:0] rsp_result_o,
  output logic              rsp_zero_o,
  output logic              rsp_err_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e state_q, state_d;

  logic              gnt;
  logic              accept;
  logic              rsp_ready_sel;

  logic [3:0]        op_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic [4:0]        shamt_q;
  logic              gnt_q;

  logic [DATA_W-1:0] alu_res;
  logic              alu_err;
  logic [DATA_W-1:0] result_q;
  logic              err_q;

  // out_valid_q rises one cycle after entering StResp, giving accept-to-valid
  // latency of two edges after the accept edge.
  logic              out_valid_q, out_valid_d;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic last_q;

  // Last-grant pointer; reset value 1 hands the first contested grant to req0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= 1'b1;
    end else if (accept) begin
      last_q <= gnt;
    end
  end
`endif

  // Grant selection: a lone requester always wins; contention resolved by policy.
  always_comb begin
    gnt = 1'b0;
    if (req0_valid_i && req1_valid_i) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
      gnt = ~last_q;
`else
      gnt = 1'b0;
`endif
    end else if (req1_valid_i) begin
      gnt = 1'b1;
    end
  end

  // Ready only in idle, only to the granted valid requester, never under reset.
  always_comb begin
    req0_ready_o = rst_ni && (state_q == StIdle) && req0_valid_i && !gnt;
    req1_ready_o = rst_ni && (state_q == StIdle) && req1_valid_i && gnt;
    accept       = req0_ready_o || req1_ready_o;
    // The non-granted requester's rsp_ready is deliberately ignored here.
    rsp_ready_sel = gnt_q ? rsp1_ready_i : rsp0_ready_i;
  end

  // Next-state logic for the idle/exec/resp sequence.
  always_comb begin
    state_d     = state_q;
    out_valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StExec;
      end
      StExec: begin
        state_d = StResp;
      end
      StResp: begin
        if (out_valid_q && rsp_ready_sel) begin
          state_d = StIdle;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and response-valid registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Capture the granted operation at accept; later input changes are ignored.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      shamt_q <= '0;
      gnt_q   <= 1'b0;
    end else if (accept) begin
      gnt_q <= gnt;
      if (gnt) begin
        op_q    <= req1_op_i;
        a_q     <= req1_a_i;
        b_q     <= req1_b_i;
        shamt_q <= req1_shamt_i;
      end else begin
        op_q    <= req0_op_i;
        a_q     <= req0_a_i;
        b_q     <= req0_b_i;
        shamt_q <= req0_shamt_i;
      end
    end
  end

  // ALU datapath on latched operands; codes 8-15 flag an error with zero result.
  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    unique case (op_q)
      4'd0:    alu_res = a_q + b_q;
      4'd1:    alu_res = a_q - b_q;
      4'd2:    alu_res = ~a_q;
      4'd3:    alu_res = a_q << shamt_q;
      4'd4:    alu_res = a_q >> shamt_q;
      4'd5:    alu_res = a_q & b_q;
      4'd6:    alu_res = a_q | b_q;
      4'd7:    alu_res = {{(DATA_W-1){1'b0}}, (a_q < b_q)};
      default: alu_err = 1'b1;
    endcase
  end

  // Register the result once, during the exec cycle, so it is stable in resp.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      result_q <= '0;
      err_q    <= 1'b0;
    end else if (state_q == StExec) begin
      result_q <= alu_res;
      err_q    <= alu_err;
    end
  end

  // Response outputs are forced to zero whenever no response is presented.
  always_comb begin
    rsp0_valid_o = out_valid_q && !gnt_q;
    rsp1_valid_o = out_valid_q && gnt_q;
    rsp_result_o = out_valid_q ? result_q : '0;
    rsp_zero_o   = out_valid_q && (result_q == '0);
    rsp_err_o    = out_valid_q && err_q;
    busy_o       = (state_q != StIdle);
  end

endmodule
